pwm_cmd_sched: RTL and testbench
================================

Name: pwm_cmd_sched

Overview:
UART-command controller that configures the PWM datapath. It parses byte commands arriving from the UART receiver and maintains NCH duty-cycle registers that drive the PWM generators. It returns a one-byte response per command through the UART transmitter byte handshake. It sits between the UART byte interfaces and the PWM channel bank inside the PwmCtrl subsystem.

Parameters:
NCH, 8, number of PWM channels (1..16)
DW, 8, duty register width in bits (fixed at one command byte)
TIMEOUT_CYC, 5000000, idle cycles allowed between bytes of one command (100 ms at 50 MHz)

Ports:
CLK  input  1  system clock, 50 MHz
RST_N  input  1  asynchronous active-low reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  controller accepts byte; transfer when rx_valid&rx_ready
tx_data  output  8  response byte
tx_valid  output  1  response valid; held until tx_ready
tx_ready  input  1  transmitter accepts byte
duty_flat  output  NCH*DW  channel i duty at [i*DW +: DW]
duty_upd  output  1  one-cycle pulse when a duty register is written
upd_ch  output  4  channel index of last write
busy  output  1  high when state != IDLE
err_cnt  output  8  saturating count of protocol errors

Behaviour:
- Reset is asynchronous (RST_N low): state=IDLE; duty_flat=0; duty_upd=0; upd_ch=0; tx_valid=0; tx_data=0; rx_ready=0; err_cnt=0; timeout counter=0. The first edge after release sets rx_ready=1.
- All outputs are registered.
- Protocol: 'W'(0x57), ch, duty writes a channel. 'R'(0x52), ch reads a channel. Any other opcode is an error.
- States and transitions:
  - IDLE: rx_ready=1. Accepting 'W' goes to GET_CH (op=W). Accepting 'R' goes to GET_CH (op=R). Accepting any other byte goes to RESP with tx_data='E' (0x45), and err_cnt increments.
  - GET_CH: latch ch. If ch>=NCH: go to RESP with 'E' and increment err_cnt. If op=W: go to GET_DUTY. If op=R: go to RESP with tx_data=duty[ch].
  - GET_DUTY: on accept, the next edge writes duty[ch]=byte, sets upd_ch=ch, pulses duty_upd for exactly one cycle, and goes to RESP with tx_data='K' (0x4B).
  - RESP: rx_ready=0 and tx_valid=1. tx_data is stable until the cycle where tx_valid&tx_ready. At that edge: tx_valid=0, rx_ready=1, state=IDLE.
- Latency: response tx_valid is asserted on the edge following acceptance of the final command byte.
- rx_ready drops on the same edge that enters RESP. Bytes presented during RESP are not accepted and are not lost; the source holds them.
- Timeout: the counter runs in GET_CH and GET_DUTY and clears on every accepted byte. When it reaches TIMEOUT_CYC-1: return to IDLE, send no response, increment err_cnt. No duty register changes.
- err_cnt saturates at 255 and never wraps.
- Writing the same duty value still pulses duty_upd.
- Reset mid-command discards the partial command. Duty registers return to 0.
- tx_ready is ignored while tx_valid=0.

Optional Feature:
PWM_CMD_READBACK_EN.
- Defined: the 'R' command is supported as described above.
- Undefined: 'R' is treated as an unknown opcode. The block returns 'E' immediately from IDLE and increments err_cnt, and the readback mux logic is not built.

Test Plan:
- Reset release, then W,3,0x80 with tx_ready=1 -> duty_flat[31:24]=0x80; duty_upd pulses once with upd_ch=3; tx_data=0x4B; other channels remain 0.
- W,9,0x10 with NCH=8 -> 'E' response after the ch byte; err_cnt=1; no duty_upd; the next command is parsed normally.
- Opcode 0x41 -> 'E' response; err_cnt=1. 256 such bytes leave err_cnt=255.
- W,2, then silence for TIMEOUT_CYC cycles -> state IDLE; no tx_valid; err_cnt+1. A following W,2,0x20 writes 0x20.
- R,3 after the first test with tx_ready held low 10 cycles -> tx_valid=1 and tx_data=0x80 stable for 10 cycles; rx_ready=0 throughout; handshake then returns to IDLE. With PWM_CMD_READBACK_EN undefined -> 'E' instead.
- RST_N pulsed low after W,5 -> all outputs at reset values asynchronously. A subsequent 0x10 byte yields 'E'; duty[5] is unchanged at 0.

Source files
------------

// File: rtl/pwm_cmd_sched.sv
// rtl/pwm_cmd_sched.sv - UART byte-command parser driving the PWM duty register bank
//
// Purpose: parses 'W' ch duty (write) and 'R' ch (read) byte commands. It keeps NCH
// duty registers and returns one response byte per command: 'K', 'E' or the duty value.
// Optional feature macro: PWM_CMD_READBACK_EN. When it is defined, the 'R' command
// is supported. When it is undefined, 'R' is treated as an unknown opcode.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   rx_data    received byte            rx_valid / rx_ready  receive handshake
//   tx_data    response byte            tx_valid / tx_ready  transmit handshake
//   duty_flat  channel i duty at [i*DW +: DW]
//   duty_upd   one-cycle pulse per duty write, upd_ch = channel of last write
//   busy       parser not idle          err_cnt              saturating protocol error count
module pwm_cmd_sched #(
  parameter int NCH         = 8,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [NCH*DW-1:0] duty_flat,
  output logic              duty_upd,
  output logic [3:0]        upd_ch,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    OP_W    = 8'h57;
  localparam logic [7:0]    RSP_E   = 8'h45;
  localparam logic [7:0]    RSP_K   = 8'h4B;
  localparam logic [7:0]    NCH_B   = 8'(NCH);

  typedef enum logic [1:0] {S_IDLE, S_GET_CH, S_GET_DUTY, S_RESP} state_t;

  state_t              r_state, w_state_nx;
  logic [3:0]          r_ch, w_ch_nx;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic [NCH*DW-1:0]   r_duty, w_duty_nx;
  logic                r_duty_upd, w_duty_upd_nx;
  logic [3:0]          r_upd_ch, w_upd_ch_nx;
  logic                r_tx_valid, w_tx_valid_nx;
  logic [7:0]          r_tx_data, w_tx_data_nx;
  logic                r_rx_ready;
  logic                r_busy;
  logic [7:0]          r_err;
  logic                w_err_inc;
  logic                w_acc;
  logic                w_to;
`ifdef PWM_CMD_READBACK_EN
  localparam logic [7:0] OP_R = 8'h52;
  logic                r_op_rd, w_op_rd_nx;
`endif

  assign w_acc = rx_valid & r_rx_ready;
  assign w_to  = (r_cnt == TO_LAST);

  always_comb begin
    w_state_nx    = r_state;
    w_ch_nx       = r_ch;
    w_cnt_nx      = r_cnt;
    w_duty_nx     = r_duty;
    w_duty_upd_nx = 1'b0;
    w_upd_ch_nx   = r_upd_ch;
    w_tx_valid_nx = r_tx_valid;
    w_tx_data_nx  = r_tx_data;
    w_err_inc     = 1'b0;
`ifdef PWM_CMD_READBACK_EN
    w_op_rd_nx    = r_op_rd;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_cnt_nx = '0;
          if (rx_data == OP_W) begin
            w_state_nx = S_GET_CH;
`ifdef PWM_CMD_READBACK_EN
            w_op_rd_nx = 1'b0;
          end else if (rx_data == OP_R) begin
            w_state_nx = S_GET_CH;
            w_op_rd_nx = 1'b1;
`endif
          end else begin
            w_state_nx    = S_RESP;
            w_tx_valid_nx = 1'b1;
            w_tx_data_nx  = RSP_E;
            w_err_inc     = 1'b1;
          end
        end
      end
      S_GET_CH: begin
        if (w_acc) begin
          w_cnt_nx = '0;
          w_ch_nx  = rx_data[3:0];
          // The full byte is range checked, so 0x13 is rejected even though its low nibble is valid.
          if (rx_data >= NCH_B) begin
            w_state_nx    = S_RESP;
            w_tx_valid_nx = 1'b1;
            w_tx_data_nx  = RSP_E;
            w_err_inc     = 1'b1;
`ifdef PWM_CMD_READBACK_EN
          end else if (r_op_rd) begin
            w_state_nx    = S_RESP;
            w_tx_valid_nx = 1'b1;
            w_tx_data_nx  = r_duty[rx_data[3:0]*DW +: DW];
`endif
          end else begin
            w_state_nx = S_GET_DUTY;
          end
        end else if (w_to) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_err_inc  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_GET_DUTY: begin
        if (w_acc) begin
          w_cnt_nx                  = '0;
          w_duty_nx[r_ch*DW +: DW]  = rx_data;
          w_duty_upd_nx             = 1'b1;
          w_upd_ch_nx               = r_ch;
          w_state_nx                = S_RESP;
          w_tx_valid_nx             = 1'b1;
          w_tx_data_nx              = RSP_K;
        end else if (w_to) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_err_inc  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (r_tx_valid && tx_ready) begin
          w_state_nx    = S_IDLE;
          w_tx_valid_nx = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_duty     <= '0;
      r_duty_upd <= 1'b0;
      r_upd_ch   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= '0;
`ifdef PWM_CMD_READBACK_EN
      r_op_rd    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_ch       <= w_ch_nx;
      r_cnt      <= w_cnt_nx;
      r_duty     <= w_duty_nx;
      r_duty_upd <= w_duty_upd_nx;
      r_upd_ch   <= w_upd_ch_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_tx_data  <= w_tx_data_nx;
      // The handshake flags are derived from the next state so that they are registered and still line up with the state.
      r_rx_ready <= (w_state_nx != S_RESP);
      r_busy     <= (w_state_nx != S_IDLE);
      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
`ifdef PWM_CMD_READBACK_EN
      r_op_rd    <= w_op_rd_nx;
`endif
    end
  end

  assign rx_ready  = r_rx_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign duty_flat = r_duty;
  assign duty_upd  = r_duty_upd;
  assign upd_ch    = r_upd_ch;
  assign busy      = r_busy;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_pwm_cmd_sched.sv
// tb/tb_pwm_cmd_sched.sv - bench for pwm_cmd_sched, command-level reference model plus directed and random traffic
module tb_pwm_cmd_sched;
  localparam int NCH = 8;
  localparam int DW  = 8;
  localparam int T   = 40;
`ifdef PWM_CMD_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              tx_ready = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [NCH*DW-1:0] duty_flat;
  logic              duty_upd;
  logic [3:0]        upd_ch;
  logic              busy;
  logic [7:0]        err_cnt;

  pwm_cmd_sched #(.NCH(NCH), .DW(DW), .TIMEOUT_CYC(T)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .duty_flat(duty_flat),
    .duty_upd(duty_upd), .upd_ch(upd_ch), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the bytes of the pending command, the idle cycles since the last byte, and the pending response.
  logic [7:0] m_cmd[$];
  int         m_silent = 0;
  bit         m_started = 1'b0;
  bit         m_resp = 1'b0;
  bit         m_upd = 1'b0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_err = 8'h00;
  logic [3:0] m_updch = 4'h0;
  logic [7:0] m_duty[NCH];

  function automatic void m_reset();
    m_cmd.delete();
    m_silent  = 0;
    m_started = 1'b0;
    m_resp    = 1'b0;
    m_upd     = 1'b0;
    m_tx      = 8'h00;
    m_err     = 8'h00;
    m_updch   = 4'h0;
    for (int i = 0; i < NCH; i++) m_duty[i] = 8'h00;
  endfunction

  function automatic void m_bump_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic void m_respond(input logic [7:0] b, input bit is_err);
    m_resp = 1'b1;
    m_tx   = b;
    if (is_err) m_bump_err();
    m_cmd.delete();
  endfunction

  initial m_reset();

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_reset();
    end else begin
      m_upd = 1'b0;
      if (m_resp) begin
        if (tx_ready) m_resp = 1'b0;
      end else if (m_started && rx_valid) begin
        m_silent = 0;
        m_cmd.push_back(rx_data);
        if (!(m_cmd[0] == 8'h57 || (RB && m_cmd[0] == 8'h52))) begin
          m_respond(8'h45, 1'b1);
        end else if (m_cmd.size() == 2) begin
          if (m_cmd[1] >= NCH) m_respond(8'h45, 1'b1);
          else if (m_cmd[0] == 8'h52) m_respond(m_duty[m_cmd[1]], 1'b0);
        end else if (m_cmd.size() == 3) begin
          m_duty[m_cmd[1]] = m_cmd[2];
          m_upd   = 1'b1;
          m_updch = m_cmd[1][3:0];
          m_respond(8'h4B, 1'b0);
        end
      end else if (m_cmd.size() != 0) begin
        m_silent++;
        if (m_silent == T) begin
          m_bump_err();
          m_cmd.delete();
          m_silent = 0;
        end
      end
      m_started = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [NCH*DW-1:0] exp_flat;
      for (int i = 0; i < NCH; i++) exp_flat[i*DW +: DW] = m_duty[i];
      n_vec++;
      chk("rx_ready", rx_ready, m_started && !m_resp);
      chk("tx_valid", tx_valid, m_resp);
      if (m_resp) chk("tx_data", tx_data, m_tx);
      chk("busy", busy, m_resp || (m_cmd.size() != 0));
      chk("duty_upd", duty_upd, m_upd);
      chk("upd_ch", upd_ch, m_updch);
      chk("err_cnt", err_cnt, m_err);
      chk("duty_flat", duty_flat, exp_flat);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    acc      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge CLK);
      acc = rx_ready;
      step();
    end
    rx_valid = 1'b0;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_bound: byte 0x%0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_duty_flat", duty_flat, 64'h0);
    chk("rst_duty_upd", duty_upd, 1'b0);
    chk("rst_upd_ch", upd_ch, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    step();
    step();
    RST_N = 1'b1;
    step();
  endtask

  initial begin
    step();
    step();
    RST_N  = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("first_rx_ready", rx_ready, 1'b0);
    step();
    tx_ready = 1'b1;

    // Write channel 3 and confirm the one-cycle update pulse and the 'K' response.
    send(8'h57); send(8'h03); send(8'h80);
    @(negedge CLK);
    chk("t1_duty_upd", duty_upd, 1'b1);
    chk("t1_upd_ch", upd_ch, 4'h3);
    chk("t1_tx_data", tx_data, 8'h4B);
    chk("t1_duty_flat", duty_flat, 64'h0000_0000_8000_0000);
    chk("t1_err", err_cnt, 8'h00);
    step();
    @(negedge CLK);
    chk("t1_upd_drop", duty_upd, 1'b0);
    chk("t1_tx_done", tx_valid, 1'b0);
    step();

    // An out-of-range channel is rejected after the channel byte, and the next command still parses.
    send(8'h57); send(8'h09);
    @(negedge CLK);
    chk("t2_tx_data", tx_data, 8'h45);
    chk("t2_err", err_cnt, 8'h01);
    chk("t2_no_upd", duty_upd, 1'b0);
    step();
    send(8'h57); send(8'h01); send(8'h11);
    @(negedge CLK);
    chk("t2_duty_flat", duty_flat, 64'h0000_0000_8000_1100);
    step();

    // Unknown opcode, then saturation of the error counter.
    do_reset();
    send(8'h41);
    @(negedge CLK);
    chk("t3_tx_data", tx_data, 8'h45);
    chk("t3_err1", err_cnt, 8'h01);
    step();
    for (int i = 0; i < 255; i++) send(8'h41);
    step();
    @(negedge CLK);
    chk("t3_err255", err_cnt, 8'hFF);
    step();
    send(8'h41);
    step();
    @(negedge CLK);
    chk("t3_err_sat", err_cnt, 8'hFF);
    step();

    // Inter-byte timeout: still busy one cycle before the limit, and idle with err+1 at the limit.
    do_reset();
    send(8'h57); send(8'h02);
    repeat (T - 1) @(posedge CLK);
    @(negedge CLK);
    chk("t4_busy_before", busy, 1'b1);
    chk("t4_err_before", err_cnt, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_no_tx", tx_valid, 1'b0);
    chk("t4_err_after", err_cnt, 8'h01);
    step();
    send(8'h57); send(8'h02); send(8'h20);
    @(negedge CLK);
    chk("t4_duty_flat", duty_flat, 64'h0000_0000_0020_0000);
    step();

    // Readback while the transmitter stalls, to check that the response is held stable.
    send(8'h57); send(8'h03); send(8'h80);
    step();
    tx_ready = 1'b0;
    send(8'h52);
    if (RB) send(8'h03);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("t5_tx_valid", tx_valid, 1'b1);
      chk("t5_tx_data", tx_data, RB ? 8'h80 : 8'h45);
      chk("t5_rx_ready", rx_ready, 1'b0);
    end
    step();
    tx_ready = 1'b1;
    step();
    @(negedge CLK);
    chk("t5_released", tx_valid, 1'b0);
    chk("t5_idle", busy, 1'b0);
    step();

    // A reset in the middle of a command discards the partial command.
    send(8'h57); send(8'h05);
    do_reset();
    send(8'h10);
    @(negedge CLK);
    chk("t6_tx_data", tx_data, 8'h45);
    chk("t6_err", err_cnt, 8'h01);
    chk("t6_duty_flat", duty_flat, 64'h0);
    step();

    // Random traffic against the model, with occasional silences long enough to trip the timeout.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rx_valid = 1'b0;
        repeat (T + 5) step();
      end else begin
        int sel;
        sel      = int'($urandom_range(0, 9));
        rx_valid = ($urandom_range(0, 2) != 0);
        if (sel <= 2)      rx_data = 8'h57;
        else if (sel <= 4) rx_data = 8'h52;
        else if (sel <= 8) rx_data = 8'($urandom_range(0, 9));
        else               rx_data = 8'($urandom);
        tx_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
